// File: rtl/inv_pkg.sv
// Shared definitions for the inverter checker: FSM state encoding,
// default stimulus pattern and the "no mismatch seen" index sentinel.
package inv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   // Bit i is driven at step i: 0,1,0,1,1,0,1,1,0,1,1,0,1
   localparam logic [31:0] DEF_PATTERN    = 32'b1011011011010;
   localparam logic [4:0]  FIRST_ERR_NONE = 5'd31;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module settle_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/inverter_checker.sv
// Drives a stimulus pattern into an inverter, waits for settling and counts
// mismatching responses. Define INVCHK_FIRST_ERR_EN to add FirstErrIdx.
module inverter_checker
   import inv_pkg::*;
#(
   parameter int                     PATTERN_LEN   = 13,
   parameter logic [PATTERN_LEN-1:0] PATTERN       = DEF_PATTERN[PATTERN_LEN-1:0],
   parameter int                     SETTLE_CYCLES = 4,
   parameter int                     ERR_W         = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   output logic             StimOut,
   input  logic             RespIn,
   output logic             Busy,
   output logic             Done,
   output logic             Pass,
   output logic [ERR_W-1:0] ErrCount,
   output logic [4:0]       BitIdx
`ifdef INVCHK_FIRST_ERR_EN
   ,
   output logic [4:0]       FirstErrIdx
`endif
);

   localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [4:0]       LAST_IDX    = 5'(PATTERN_LEN - 1);
   localparam logic [31:0]      PAT32       = 32'(PATTERN);

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   state_t           state_q, state_d;
   logic             stim_q, stim_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [4:0]       idx_q, idx_d;
`ifdef INVCHK_FIRST_ERR_EN
   logic [4:0]       first_err_q, first_err_d;
`endif

   logic tmr_load;
   logic tmr_en;
   logic tmr_expired;
   logic mismatch;

   settle_timer #(
      .CNT_W (CNT_W)
   ) u_settle_timer (
      .clk      (Clock),
      .rst      (Reset),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (SETTLE_LOAD),
      .expired  (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      stim_d   = stim_q;
      pass_d   = pass_q;
      err_d    = err_q;
      idx_d    = idx_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      mismatch = RespIn ^ ~stim_q;
`ifdef INVCHK_FIRST_ERR_EN
      first_err_d = first_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d  = ST_SETTLE;
               stim_d   = PAT32[0];
               idx_d    = '0;
               err_d    = '0;
               pass_d   = 1'b0;
               tmr_load = 1'b1;
`ifdef INVCHK_FIRST_ERR_EN
               first_err_d = FIRST_ERR_NONE;
`endif
            end
         end
         ST_SETTLE: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               err_d = sat_inc(err_q);
`ifdef INVCHK_FIRST_ERR_EN
               // A zero count means this is the first mismatch of the run
               if (err_q == '0) begin
                  first_err_d = idx_q;
               end
`endif
            end
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d  = ST_SETTLE;
               idx_d    = idx_q + 5'd1;
               stim_d   = PAT32[idx_d];
               tmr_load = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status outputs are registered alongside the state they describe
      busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         stim_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         idx_q   <= '0;
`ifdef INVCHK_FIRST_ERR_EN
         first_err_q <= FIRST_ERR_NONE;
`endif
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
`ifdef INVCHK_FIRST_ERR_EN
         first_err_q <= first_err_d;
`endif
      end
   end

   assign StimOut  = stim_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Pass     = pass_q;
   assign ErrCount = err_q;
   assign BitIdx   = idx_q;
`ifdef INVCHK_FIRST_ERR_EN
   assign FirstErrIdx = first_err_q;
`endif

endmodule

// File: tb/tb_inverter_checker.sv
// Bench for inverter_checker: default-width instance plus an ERR_W=2 instance,
// driven by a small response-mode table and a Done-triggered scoreboard.
module tb_inverter_checker;

   localparam int LEN    = 13;
   localparam int SETTLE = 4;
   localparam int STEP   = SETTLE + 1;

   typedef struct {
      logic [1:0] mode;
      int         err;
      int         err2;
      logic       pass;
      int         first;
   } vec_t;

   typedef struct {
      int err;
      int err2;
      int pass;
      int first;
   } scb_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [1:0] mode;
   logic hold_mode;

   logic       stim_a, resp_a, busy_a, done_a, pass_a;
   logic [7:0] err_a;
   logic [4:0] idx_a;
   logic       stim_b, resp_b, busy_b, done_b, pass_b;
   logic [1:0] err_b;
   logic [4:0] idx_b;
`ifdef INVCHK_FIRST_ERR_EN
   logic [4:0] fe_a, fe_b;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   scb_t exp_q[$];
   scb_t mon_e;
   vec_t vecs[4];
   logic seq[LEN];

   always #5 clk = ~clk;

   // 0: ideal inverter, 1: buffer, 2: stuck at 0, 3: stuck at 1
   function automatic logic resp_of(input logic [1:0] m, input logic s);
      case (m)
         2'd0:    return ~s;
         2'd1:    return s;
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   assign resp_a = resp_of(mode, stim_a);
   assign resp_b = resp_of(mode, stim_b);

   inverter_checker u_dut_a (
      .Clock    (clk),
      .Reset    (rst),
      .Start    (start),
      .StimOut  (stim_a),
      .RespIn   (resp_a),
      .Busy     (busy_a),
      .Done     (done_a),
      .Pass     (pass_a),
      .ErrCount (err_a),
      .BitIdx   (idx_a)
`ifdef INVCHK_FIRST_ERR_EN
      ,
      .FirstErrIdx (fe_a)
`endif
   );

   inverter_checker #(.ERR_W(2)) u_dut_b (
      .Clock    (clk),
      .Reset    (rst),
      .Start    (start),
      .StimOut  (stim_b),
      .RespIn   (resp_b),
      .Busy     (busy_b),
      .Done     (done_b),
      .Pass     (pass_b),
      .ErrCount (err_b),
      .BitIdx   (idx_b)
`ifdef INVCHK_FIRST_ERR_EN
      ,
      .FirstErrIdx (fe_b)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_stim"}, int'(stim_a), 0);
      chk({tag, "_busy"}, int'(busy_a), 0);
      chk({tag, "_done"}, int'(done_a), 0);
      chk({tag, "_pass"}, int'(pass_a), 0);
      chk({tag, "_err"}, int'(err_a), 0);
      chk({tag, "_idx"}, int'(idx_a), 0);
      chk({tag, "_err_w2"}, int'(err_b), 0);
      chk({tag, "_done_w2"}, int'(done_b), 0);
`ifdef INVCHK_FIRST_ERR_EN
      chk({tag, "_first_err"}, int'(fe_a), 31);
`endif
   endtask

   // Scoreboard: every Done pops the expectation pushed when its Start was driven
   always @(negedge clk) begin
      if (done_a === 1'b1 && !hold_mode) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", int'(done_a), 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("err_count", int'(err_a), mon_e.err);
            chk("err_count_w2", int'(err_b), mon_e.err2);
            chk("pass", int'(pass_a), mon_e.pass);
            chk("pass_w2", int'(pass_b), mon_e.pass);
            chk("done_w2_aligned", int'(done_b), 1);
            chk("bitidx_at_done", int'(idx_a), LEN - 1);
            chk("stim_held_at_done", int'(stim_a), int'(seq[LEN-1]));
            chk("busy_at_done", int'(busy_a), 0);
`ifdef INVCHK_FIRST_ERR_EN
            chk("first_err_idx", int'(fe_a), mon_e.first);
`endif
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int   n;
      int   bad;
      int   step;
      logic seen;
      scb_t s;
      mode = v.mode;
      @(negedge clk);
      start = 1'b1;
      s.err = v.err; s.err2 = v.err2; s.pass = int'(v.pass); s.first = v.first;
      exp_q.push_back(s);
      @(negedge clk);
      start = 1'b0;
      n = 1; bad = 0; seen = 1'b0;
      while (n <= 200) begin
         if (done_a === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step = (n - 1) / STEP;
         if (step >= LEN || busy_a !== 1'b1 || int'(idx_a) != step || stim_a !== seq[step])
            bad++;
         @(negedge clk);
         n++;
      end
      chk("done_seen", int'(seen), 1);
      chk("done_latency", n, 66);
      chk("stim_sequence_errors", bad, 0);
      if (!seen) exp_q.delete();
      @(negedge clk);
      chk("done_one_cycle", int'(done_a), 0);
      chk("idle_not_busy", int'(busy_a), 0);
      chk("pass_holds_idle", int'(pass_a), int'(v.pass));
      chk("err_holds_idle", int'(err_a), v.err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dtimes[$];
      int n;
      int dcount;
      int idle_wait;

      vecs[0] = '{mode: 2'd0, err: 0,  err2: 0, pass: 1'b1, first: 31};
      vecs[1] = '{mode: 2'd1, err: 13, err2: 3, pass: 1'b0, first: 0};
      vecs[2] = '{mode: 2'd2, err: 5,  err2: 3, pass: 1'b0, first: 0};
      vecs[3] = '{mode: 2'd3, err: 8,  err2: 3, pass: 1'b0, first: 1};
      seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; mode = 2'd0; hold_mode = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Reset during a run: immediate effect, no Done, then a clean run
      mode = 2'd1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_values("async_reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values("abort_reset");
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done_a === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_err_stays_zero", int'(err_a), 0);
      run_vec(vecs[0]);

      // Start held high: back-to-back runs, Start ignored while busy
      hold_mode = 1'b1;
      mode = 2'd0;
      @(negedge clk);
      start = 1'b1;
      for (n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            dtimes.push_back(n);
            chk("hold_err", int'(err_a), 0);
            chk("hold_pass", int'(pass_a), 1);
         end
      end
      start = 1'b0;
      chk("hold_done_count_ge2", int'(dtimes.size() >= 2), 1);
      if (dtimes.size() >= 1) chk("hold_first_latency", dtimes[0], 66);
      for (int i = 1; i < dtimes.size(); i++)
         chk("hold_done_spacing", dtimes[i] - dtimes[i-1], 67);
      idle_wait = 0;
      while ((busy_a === 1'b1 || done_a === 1'b1) && idle_wait < 100) begin
         @(negedge clk);
         idle_wait++;
      end
      chk("hold_drain_idle", int'(busy_a), 0);
      hold_mode = 1'b0;

      run_vec(vecs[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inverter_checker.md
INVERTER_CHECKER -- requirements
Module: inverter_checker

Interface
REQ-001 The block SHALL have parameter PATTERN_LEN, default 13, giving the number of stimulus bits per run (1..32).
REQ-002 The block SHALL have parameter PATTERN, default 13'b1011011011010, giving the stimulus bits; bit i is driven at step i, so the default sequence is 0,1,0,1,1,0,1,1,0,1,1,0,1.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles the response may settle before sampling (minimum 1).
REQ-004 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-005 The block SHALL have port Clock, input, 1, the single clock, with all state updated on the rising edge.
REQ-006 The block SHALL have port Reset, input, 1, which is asynchronous and active-high.
REQ-007 The block SHALL have port Start, input, 1, which requests a run and is sampled only in IDLE.
REQ-008 The block SHALL have port StimOut, output, 1, the registered stimulus bit driven to the inverter input.
REQ-009 The block SHALL have port RespIn, input, 1, the inverter output under test, treated as synchronous to Clock.
REQ-010 The block SHALL have port Busy, output, 1, which is high in states SETTLE and CHECK.
REQ-011 The block SHALL have port Done, output, 1, a one-cycle pulse marking the end of a run.
REQ-012 The block SHALL have port Pass, output, 1, which is high when the last completed run had ErrCount equal to 0.
REQ-013 The block SHALL have port ErrCount, output, ERR_W, the saturating count of mismatches.
REQ-014 The block SHALL have port BitIdx, output, 5, the index of the current step.

Function
REQ-015 The state machine SHALL have states IDLE, SETTLE, CHECK and DONE.
REQ-016 In IDLE with Start=1, the next edge SHALL load StimOut=PATTERN[0], set BitIdx=0, clear ErrCount, clear Pass, clear the settle counter and enter SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then enter CHECK.
REQ-018 On the edge leaving CHECK, the block SHALL compare RespIn with ~StimOut and increment ErrCount on a mismatch, saturating at all-ones.
REQ-019 On leaving CHECK with BitIdx<PATTERN_LEN-1, the block SHALL increment BitIdx, load StimOut=PATTERN[BitIdx+1] and re-enter SETTLE.
REQ-020 On leaving CHECK with BitIdx=PATTERN_LEN-1, the block SHALL enter DONE and keep StimOut unchanged.
REQ-021 DONE SHALL last one cycle, assert Done during it, and set Pass=(final ErrCount==0) for that cycle; the block SHALL then return to IDLE.
REQ-022 Pass and ErrCount SHALL hold their values in IDLE until the next accepted Start.
REQ-023 Each step SHALL take SETTLE_CYCLES+1 cycles, and Done SHALL assert PATTERN_LEN*(SETTLE_CYCLES+1)+1 cycles after the Start-accepting edge.
REQ-024 Start SHALL be ignored outside IDLE, and Start held high SHALL begin a new run on the first IDLE cycle after DONE.

Reset
REQ-025 While Reset is high, the block SHALL be in IDLE with StimOut=0, Busy=0, Done=0, Pass=0, ErrCount=0 and BitIdx=0, taking effect immediately and asynchronously.
REQ-026 Reset asserted mid-run SHALL abort the run, produce no Done pulse, and leave all outputs at their reset values.

Configuration
REQ-027 With macro INVCHK_FIRST_ERR_EN defined, the block SHALL add output FirstErrIdx (5 bits, reset 31) that captures BitIdx of the first mismatch in a run, is set to 31 at Start and holds until the next Start.
REQ-028 Without INVCHK_FIRST_ERR_EN, the block SHALL have neither the FirstErrIdx port nor its register, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package inv_pkg SHALL hold the state encoding typedef, the default PATTERN constant and the FirstErrIdx sentinel value 31.
REQ-030 The settle timer SHALL be a separate sub-module named settle_timer, a loadable down-counter that signals expiry.

Verification
REQ-031 Reset held for 3 cycles -> all outputs SHALL read 0, and with INVCHK_FIRST_ERR_EN defined FirstErrIdx SHALL read 31.
REQ-032 RespIn=~StimOut, Start pulsed -> StimOut SHALL follow 0,1,0,1,1,0,1,1,0,1,1,0,1, Done SHALL assert 66 cycles after accept, and ErrCount=0 with Pass=1.
REQ-033 RespIn=StimOut (a buffer) -> ErrCount SHALL be 13 and Pass SHALL be 0; with ERR_W=2, ErrCount SHALL saturate at 3.
REQ-034 RespIn stuck at 0 -> ErrCount SHALL be 5 (the mismatches at steps 0,2,5,8,11), Pass SHALL be 0, and FirstErrIdx SHALL be 0.
REQ-035 Reset asserted at cycle 20 of a run -> there SHALL be no Done pulse and all outputs SHALL be at reset values; a following Start SHALL complete normally.
REQ-036 Start held high for 200 cycles with an ideal inverter -> Start SHALL be ignored while Busy, and there SHALL be back-to-back runs with Done 67 cycles apart.
